aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Sequences one AES-128 encryption on the shared 32-bit AES ALU, issuing one ALU op per cycle.
//  Holds the 128-bit state and the rolling round key, and drives the ALU operands and opcode.
//  Captures alu_result on the same edge, because the ALU is purely combinational.
//  Sits between the CPU block-cipher instruction front end and the ALU.
//  The key schedule is computed on the fly, one round key at a time, with no key RAM.
// PARAMETERS
//  NROUNDS  10  number of full rounds; the last round omits MixColumns
//  W        32  ALU word width; the block is only correct at 32
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    one clock; reset is synchronous and active-low
//  start          in   1    begin encryption; sampled only in IDLE or DONE
//  plaintext      in   128  FIPS-197 byte order: [127:120] = in0 = s[0][0], column-major
//  key            in   128  cipher key, same byte order; sampled with start
//  busy           out  1    high from the edge after start is accepted until done
//  done           out  1    one-cycle pulse; ciphertext valid from this cycle
//  ciphertext     out  128  result; holds until the next start is accepted
//  round          out  4    current round 0..NROUNDS (debug)
//  alu_control    out  4    ALU opcode: 0000 XOR, 0001 row rotate, 0010 SubBytes, 0011 MixColumn
//  alu_src_a      out  32   operand A
//  alu_src_b      out  32   operand B
//  alu_src_c      out  32   MixColumn column operand
//  alu_index      out  2    rotate amount for op 0001
//  alu_column     out  2    driven 0
//  alu_last_data  out  8    driven 0
//  alu_result     in   32   combinational ALU result
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, ciphertext=0, round=0.
//   ALU outputs: alu_control=4'b1111, all other ALU outputs 0.
//   The ALU idle code 1111 yields 0. Reset mid-operation aborts with no done pulse.
//  Accepting start: in IDLE or DONE, start=1 loads plaintext and key and enters ARK0.
//  FSM states: IDLE, ARK0, SUB, SHIFT, MIX, KEXP, ARK, DONE. A 2-bit step counter indexes row/column/word.
//   ARK0  4 cyc  op 0000; A = state column c, B = key word c; result -> column c
//   SUB   4 cyc  op 0010; A = state row r; result -> row r
//   SHIFT 4 cyc  op 0001; A = row r, index = r; result -> row r
//   MIX   4 cyc  op 0011; C = column c; result -> column c; skipped when round==NROUNDS
//   KEXP  7 cyc  compute the next round key:
//                1) op 0001, index 1: RotWord(w3)
//                2) op 0010: SubWord
//                3) op 0000 with B = {rcon[round],24'h0}
//                4) op 0000 with w0 -> new w0
//                5-7) op 0000: w1^w0, w2^w1, w3^w2
//   ARK   4 cyc  as ARK0, using the new key
//  round increments on entry to SUB. Order per round: SUB, SHIFT, MIX, KEXP, ARK.
//   After ARK with round==NROUNDS -> DONE; otherwise -> SUB.
//  Latency: 4 + 9*23 + 19 = 230 op cycles. done rises at the 230th edge after the start edge.
//  DONE: lasts exactly one cycle. ciphertext <= state; busy=0.
//   start=1 in DONE restarts immediately; otherwise -> IDLE.
//  start while busy: ignored, no queuing. plaintext/key changes while busy: no effect.
//  Outside active ops, unused ALU operands are 0, so the ALU never sees X.
//  State columns and rows are pure wiring views of one 16-byte array; no ALU op transposes.
// STRUCTURE
//  Package aes_seq_pkg:
//   - state enum
//   - ALU opcode localparams shared with the ALU decoder (OP_XOR, OP_ROT, OP_SUB, OP_MIX, OP_IDLE)
//   - RCON[1:10] table
//   - byte/row/column helper functions
//  One sub-module, aes_key_regs: 4x32 round-key register with per-word write enable and a temp word.
//  The ALU itself is not instantiated here; the parent connects it.
// TESTING
//  1) Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> ct 3925841d02dc09fbdc118597196a0b32, with done exactly 230 cycles after the start edge.
//  2) Key 000102..0f, pt 00112233..eeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
//  3) Internal check with vector 1: final round key -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//     Round 10 issues no op 0011.
//  4) Drop rst_n at cycle 100 of a run -> next edge: IDLE, busy=0, alu_control=1111.
//     No done pulse; a fresh start still passes vector 1.
//  5) Pulse start again at cycles 1 and 150 while busy -> ignored; ct unchanged, timing unchanged.
//  6) Hold start=1 through done with new pt/key -> back-to-back runs.
//     Second ct correct; busy low for exactly the DONE cycle.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types, ALU opcodes, round constants and state-array views for the AES round sequencer.
// No logic of its own; the helpers are pure wiring views.
// Byte k of a 128-bit block sits at [127-8k -: 8] and holds s[k%4][k/4], so the layout is column-major.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_ARK0, S_SUB, S_SHIFT, S_MIX, S_KEXP, S_ARK, S_DONE
    } seq_state_t;

    localparam logic [3:0] OP_XOR  = 4'b0000;
    localparam logic [3:0] OP_ROT  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MIX  = 4'b0011;
    localparam logic [3:0] OP_IDLE = 4'b1111;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        return s[32*(3-int'(c)) +: 32];
    endfunction

    function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] v);
        logic [127:0] res;
        res = s;
        res[32*(3-int'(c)) +: 32] = v;
        return res;
    endfunction

    // Row r is {s[r][0], s[r][1], s[r][2], s[r][3]}, column 0 in the MSB.
    function automatic logic [31:0] get_row(input logic [127:0] s, input logic [1:0] r);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++)
            res[8*(3-i) +: 8] = s[8*(15-(int'(r)+4*i)) +: 8];
        return res;
    endfunction

    function automatic logic [127:0] set_row(input logic [127:0] s, input logic [1:0] r,
                                             input logic [31:0] v);
        logic [127:0] res;
        res = s;
        for (int i = 0; i < 4; i++)
            res[8*(15-(int'(r)+4*i)) +: 8] = v[8*(3-i) +: 8];
        return res;
    endfunction

endpackage

// File: rtl/aes_key_regs.sv
// Rolling AES-128 round key (four words, word 0 in the MSBs) plus one scratch word.
// Latency: writes land on the next edge; a whole-key load takes priority over word writes.
// Backpressure: none, writes are unconditional when enabled.
module aes_key_regs
    import aes_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] key_in,
    input  logic [3:0]   word_we,
    input  logic         tmp_we,
    input  logic [31:0]  wr_dat,
    output logic [127:0] key_words,
    output logic [31:0]  tmp_word
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_words <= '0;
            tmp_word  <= '0;
        end else begin
            if (load) begin
                key_words <= key_in;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (word_we[i]) key_words[32*(3-i) +: 32] <= wr_dat;
            end
            if (tmp_we) tmp_word <= wr_dat;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Drives one AES-128 encryption through an external combinational 32-bit ALU, one op per cycle.
// Latency: 230 cycles from the start edge to the done pulse; the key schedule runs inline.
// Backpressure: start is only taken in IDLE or DONE; requests while busy are dropped.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NROUNDS = 10,
    parameter int W       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [127:0]   plaintext,
    input  logic [127:0]   key,
    output logic           busy,
    output logic           done,
    output logic [127:0]   ciphertext,
    output logic [3:0]     round,
    output logic [3:0]     alu_control,
    output logic [W-1:0]   alu_src_a,
    output logic [W-1:0]   alu_src_b,
    output logic [W-1:0]   alu_src_c,
    output logic [1:0]     alu_index,
    output logic [1:0]     alu_column,
    output logic [7:0]     alu_last_data,
    input  logic [W-1:0]   alu_result
);

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    seq_state_t   state, state_nxt;
    logic [2:0]   step;
    logic         step_last;
    logic         accept;
    logic [127:0] st;
    logic [127:0] key_words;
    logic [31:0]  tmp_word;
    logic [3:0]   key_we;
    logic         tmp_we;

    assign accept        = start && (state == S_IDLE || state == S_DONE);
    assign alu_column    = '0;
    assign alu_last_data = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        step_last = (state == S_KEXP) ? (step == 3'd6) : (step == 3'd3);
        case (state)
            S_IDLE:  if (start)     state_nxt = S_ARK0;
            S_ARK0:  if (step_last) state_nxt = S_SUB;
            S_SUB:   if (step_last) state_nxt = S_SHIFT;
            S_SHIFT: if (step_last) state_nxt = (round == LAST_ROUND) ? S_KEXP : S_MIX;
            S_MIX:   if (step_last) state_nxt = S_KEXP;
            S_KEXP:  if (step_last) state_nxt = S_ARK;
            S_ARK:   if (step_last) state_nxt = (round == LAST_ROUND) ? S_DONE : S_SUB;
            S_DONE:  state_nxt = start ? S_ARK0 : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        alu_control = OP_IDLE;
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_src_c   = '0;
        alu_index   = '0;
        key_we      = '0;
        tmp_we      = 1'b0;
        case (state)
            S_ARK0, S_ARK: begin
                busy        = 1'b1;
                alu_control = OP_XOR;
                alu_src_a   = get_col(st, step[1:0]);
                alu_src_b   = get_col(key_words, step[1:0]);
            end
            S_SUB: begin
                busy        = 1'b1;
                alu_control = OP_SUB;
                alu_src_a   = get_row(st, step[1:0]);
            end
            S_SHIFT: begin
                busy        = 1'b1;
                alu_control = OP_ROT;
                alu_src_a   = get_row(st, step[1:0]);
                alu_index   = step[1:0];
            end
            S_MIX: begin
                busy        = 1'b1;
                alu_control = OP_MIX;
                alu_src_c   = get_col(st, step[1:0]);
            end
            S_KEXP: begin
                busy        = 1'b1;
                alu_control = OP_XOR;
                // Steps 0-2 build SubWord(RotWord(w3))^rcon in tmp, then 3-6 ripple w0..w3.
                case (step)
                    3'd0: begin
                        alu_control = OP_ROT;
                        alu_src_a   = get_col(key_words, 2'd3);
                        alu_index   = 2'd1;
                        tmp_we      = 1'b1;
                    end
                    3'd1: begin
                        alu_control = OP_SUB;
                        alu_src_a   = tmp_word;
                        tmp_we      = 1'b1;
                    end
                    3'd2: begin
                        alu_src_a = tmp_word;
                        alu_src_b = {rcon(round), 24'h0};
                        tmp_we    = 1'b1;
                    end
                    3'd3: begin
                        alu_src_a = tmp_word;
                        alu_src_b = get_col(key_words, 2'd0);
                        key_we    = 4'b0001;
                    end
                    3'd4: begin
                        alu_src_a = get_col(key_words, 2'd1);
                        alu_src_b = get_col(key_words, 2'd0);
                        key_we    = 4'b0010;
                    end
                    3'd5: begin
                        alu_src_a = get_col(key_words, 2'd2);
                        alu_src_b = get_col(key_words, 2'd1);
                        key_we    = 4'b0100;
                    end
                    default: begin
                        alu_src_a = get_col(key_words, 2'd3);
                        alu_src_b = get_col(key_words, 2'd2);
                        key_we    = 4'b1000;
                    end
                endcase
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step       <= '0;
            round      <= '0;
            st         <= '0;
            ciphertext <= '0;
        end else begin
            if (step_last || state == S_IDLE || state == S_DONE) step <= '0;
            else                                                 step <= step + 3'd1;
            if (accept) begin
                round <= '0;
                st    <= plaintext;
            end else begin
                if (state_nxt == S_SUB && state != S_SUB) round <= round + 4'd1;
                case (state)
                    S_ARK0, S_ARK, S_MIX: st <= set_col(st, step[1:0], alu_result);
                    S_SUB, S_SHIFT:       st <= set_row(st, step[1:0], alu_result);
                    default: ;
                endcase
                // The final column arrives from the ALU on the same edge that enters DONE.
                if (state == S_ARK && step_last && round == LAST_ROUND)
                    ciphertext <= {st[127:32], alu_result};
            end
        end
    end

    aes_key_regs u_keys (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .key_in    (key),
        .word_we   (key_we),
        .tmp_we    (tmp_we),
        .wr_dat    (alu_result),
        .key_words (key_words),
        .tmp_word  (tmp_word)
    );

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer with a behavioural model of the shared AES ALU.
module tb_aes_round_sequencer;

    localparam logic [127:0] V1K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V1C = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V1RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V2K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [3:0]   round;
    logic [3:0]   alu_control;
    logic [31:0]  alu_src_a;
    logic [31:0]  alu_src_b;
    logic [31:0]  alu_src_c;
    logic [1:0]   alu_index;
    logic [1:0]   alu_column;
    logic [7:0]   alu_last_data;
    logic [31:0]  alu_result;

    int errors = 0;
    int checks = 0;
    int mix_total = 0;
    int mix_r10 = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .plaintext     (plaintext),
        .key           (key),
        .busy          (busy),
        .done          (done),
        .ciphertext    (ciphertext),
        .round         (round),
        .alu_control   (alu_control),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_src_c     (alu_src_c),
        .alu_index     (alu_index),
        .alu_column    (alu_column),
        .alu_last_data (alu_last_data),
        .alu_result    (alu_result)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
                xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
    endfunction

    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = alu_src_a ^ alu_src_b;
            4'b0001:
                case (alu_index)
                    2'd0:    alu_result = alu_src_a;
                    2'd1:    alu_result = {alu_src_a[23:0], alu_src_a[31:24]};
                    2'd2:    alu_result = {alu_src_a[15:0], alu_src_a[31:16]};
                    default: alu_result = {alu_src_a[7:0], alu_src_a[31:8]};
                endcase
            4'b0010: alu_result = {sbox(alu_src_a[31:24]), sbox(alu_src_a[23:16]),
                                   sbox(alu_src_a[15:8]), sbox(alu_src_a[7:0])};
            4'b0011: alu_result = mixcol(alu_src_c);
            default: alu_result = '0;
        endcase
    end

    always @(negedge clk) begin
        if (alu_control == 4'b0011) begin
            mix_total++;
            if (round == 4'd10) mix_r10++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start_run(input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] exp_ct, input bit push);
        @(negedge clk);
        key = k; plaintext = p; start = 1'b1;
        if (push) exp_q.push_back(exp_ct);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; key = '0; plaintext = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL reset_ct: got %h want 0", ciphertext); end
        checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", round); end
        checks++; if (alu_control !== 4'b1111) begin errors++; $display("FAIL reset_ctrl: got %b want 1111", alu_control); end
        checks++; if ({alu_src_a, alu_src_b, alu_src_c} !== 96'h0) begin errors++; $display("FAIL reset_srcs: got %h %h %h want 0", alu_src_a, alu_src_b, alu_src_c); end
        checks++; if ({alu_index, alu_column, alu_last_data} !== 12'h0) begin errors++; $display("FAIL reset_misc: got %h want 0", {alu_index, alu_column, alu_last_data}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vector(input string name, input logic [127:0] k, input logic [127:0] p,
                               input logic [127:0] c);
        int cyc;
        logic [127:0] e;
        start_run(k, p, c, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b want 1", name, busy); end
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++; if (cyc != 230) begin errors++; $display("FAIL %s latency: got %0d want 230", name, cyc); end
        checks++; if (ciphertext !== e) begin errors++; $display("FAIL %s ct: got %h want %h", name, ciphertext, e); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy); end
        checks++; if (ciphertext !== e) begin errors++; $display("FAIL %s ct_hold: got %h want %h", name, ciphertext, e); end
    endtask

    task automatic test_key_schedule;
        mix_total = 0; mix_r10 = 0;
        test_vector("vec1", V1K, V1P, V1C);
        checks++; if (dut.u_keys.key_words !== V1RK10) begin errors++; $display("FAIL rk10: got %h want %h", dut.u_keys.key_words, V1RK10); end
        checks++; if (mix_r10 != 0) begin errors++; $display("FAIL mix_round10: got %0d want 0", mix_r10); end
        checks++; if (mix_total != 36) begin errors++; $display("FAIL mix_total: got %0d want 36", mix_total); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int n_done;
        start_run(V1K, V1P, V1C, 1'b0);
        for (cyc = 0; cyc < 100; cyc++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (alu_control !== 4'b1111) begin errors++; $display("FAIL midrst_ctrl: got %b want 1111", alu_control); end
        checks++; if (round !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL midrst_round_done: got %0d %b want 0 0", round, done); end
        checks++; if (ciphertext !== 128'h0) begin errors++; $display("FAIL midrst_ct: got %h want 0", ciphertext); end
        rst_n = 1'b1;
        n_done = 0;
        repeat (240) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_done); end
        test_vector("after_rst", V1K, V1P, V1C);
    endtask

    task automatic test_start_while_busy;
        int cyc;
        logic [127:0] e;
        start_run(V1K, V1P, V1C, 1'b1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 1 || cyc == 150);
            if (cyc == 1 || cyc == 150) begin key = V2K; plaintext = V2P; end
            if (cyc == 80) begin key = {4{$urandom}}; plaintext = {4{$urandom}}; end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        checks++; if (cyc != 230) begin errors++; $display("FAIL busy_start latency: got %0d want 230", cyc); end
        checks++; if (ciphertext !== e) begin errors++; $display("FAIL busy_start ct: got %h want %h", ciphertext, e); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start no_queue: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic busy_before;
        logic [127:0] e;
        @(negedge clk);
        key = V1K; plaintext = V1P; start = 1'b1;
        exp_q.push_back(V1C);
        @(negedge clk);
        key = V2K; plaintext = V2P;
        exp_q.push_back(V2C);
        cyc = 0; busy_before = 1'b0;
        while (done !== 1'b1 && cyc < 400) begin
            busy_before = busy;
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        checks++; if (cyc != 230) begin errors++; $display("FAIL b2b first latency: got %0d want 230", cyc); end
        checks++; if (ciphertext !== e) begin errors++; $display("FAIL b2b first ct: got %h want %h", ciphertext, e); end
        checks++; if (busy_before !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b busy_gap: got before=%b at_done=%b want 1 0", busy_before, busy); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b restart: got busy=%b done=%b want 1 0", busy, done); end
        wait_done(cyc);
        e = exp_q.pop_front();
        checks++; if (cyc != 230) begin errors++; $display("FAIL b2b second latency: got %0d want 230", cyc); end
        checks++; if (ciphertext !== e) begin errors++; $display("FAIL b2b second ct: got %h want %h", ciphertext, e); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key = '0; plaintext = '0;
        test_reset();
        test_key_schedule();
        test_vector("vec2", V2K, V2P, V2C);
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
